serial_addsub: RTL and testbench

- Bit-serial adder/subtractor built around a single one-bit full-adder/full-subtractor cell.
- Consumes two parallel WIDTH-bit operands on a start handshake and processes one bit per clock, LSB first.
- Returns a parallel result plus carry-out (add) or borrow-out (subtract).
- It is the sequential, reverse-capable counterpart of the lab full-adder cell, and is used wherever an area-cheap multi-bit add/subtract is needed.

---
 rtl/serial_addsub.sv | 105 ++++++++++
 tb/tb_serial_addsub.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/full-subtractor cell, LSB first,
// WIDTH cycles per operation with a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
  logic             sub_q, sub_d, flag_q, flag_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic x, y, s_bit, c_bit, last;

  // One-bit cell: sum/difference bit is shared, carry vs borrow differs.
  assign x     = a_q[0];
  assign y     = b_q[0];
  assign s_bit = x ^ y ^ flag_q;
  assign c_bit = sub_q ? ((~x & y) | (flag_q & ~(x ^ y)))
                       : ((x & y) | (flag_q & (x ^ y)));
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    flag_d   = flag_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          flag_d  = 1'b0;
          cnt_d   = '0;
          sh_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        flag_d = c_bit;
        cnt_d  = cnt_q + CW'(1);
        sh_d   = {s_bit, sh_q[WIDTH-1:1]};
        if (last) begin
          // Architectural outputs only move on completion so they stay stable
          // through the next operation.
          result_d = {s_bit, sh_q[WIDTH-1:1]};
          cout_d   = c_bit;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      sh_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign c_out  = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and swept checks of serial_addsub handshake timing and arithmetic.
module tb_serial_addsub;
  localparam int W = 8;

  logic         clk, rst_n, start, op_sub;
  logic [W-1:0] a, b, result;
  logic         busy, done, c_out;

  int vec  = 0;
  int errs = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .c_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction with timing checks. noisy scrambles operands during RUN
  // and pulses start mid-RUN and in DONE, both of which must be ignored.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic ts, input logic [W-1:0] er, input logic ec,
                       input bit noisy);
    @(negedge clk);
    a = ta; b = tb_v; op_sub = ts; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".done0"}, done, 0);
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      start = noisy && (i == 3);
      if (noisy) begin
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      end
      @(posedge clk); #1;
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".nodone"}, done, 0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busyD"}, busy, 0);
    chk({tag, ".result"}, result, er);
    chk({tag, ".c_out"}, c_out, ec);
    @(negedge clk);
    if (noisy) begin
      start = 1'b1; a = 8'h77; b = 8'h11; op_sub = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".hold_res"}, result, er);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rs, ec;
    logic [W:0]   sum;

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.result", result, 0);
    chk("rst.c_out", c_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.busy", busy, 0);

    do_op("add5A3C", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    do_op("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    do_op("addFFFF", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 0);
    do_op("sub0509", 8'h05, 8'h09, 1'b1, 8'hFC, 1'b1, 0);
    do_op("sub3C3C", 8'h3C, 8'h3C, 1'b1, 8'h00, 1'b0, 0);
    // Ignored starts plus scrambled operands; next op immediately follows.
    do_op("noisy_add", 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1);
    do_op("after_done", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 0);
    do_op("noisy_sub", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1);

    // Abort mid-operation with asynchronous reset.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.result", result, 0);
    chk("abort.c_out", c_out, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort.nodone", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("abort.idle", {busy, done}, 0);
    end
    do_op("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

    // Random sweep against a plain arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (rs) begin
        er = ra - rb; ec = (ra < rb);
      end else begin
        sum = {1'b0, ra} + {1'b0, rb};
        er = sum[W-1:0]; ec = sum[W];
      end
      do_op("sweep", ra, rb, rs, er, ec, (n % 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
